// File: rtl/button_conditioner.sv
// Two-channel pushbutton front end: 2-flop synchroniser plus per-channel debounce FSM.
// Latency: DB_CYCLES+1 clk edges from a raw level change to the btn_level / pulse update.
// Backpressure: none; the pulses are fire-and-forget single-cycle strobes.
module button_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_level,
    output logic [1:0] btn_pulse,
    output logic [1:0] btn_release
);

    // Debounce FSM encoding, shared by both channels.
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // The wait states accept the new level once the sample count reaches this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0] sync1_d, sync1_q;
    logic [1:0] s_d, s_q;

    // Synchroniser next-state: raw input into stage 1, stage 1 into the used sample.
    always_comb begin
        sync1_d = btn_raw;
        s_d     = sync1_q;
    end

    // Synchroniser flops; both stages clear on reset so a held button needs a full debounce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            s_q     <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [1:0]       state_d, state_q;
        logic [CNT_W-1:0] cnt_d, cnt_q;
        logic             level_d, level_q;
        logic             pulse_d, pulse_q;
        logic             rel_d, rel_q;
        logic             s;

        assign s = s_q[g];

        // Debounce decision: a single opposite sample in a wait state falls back to the old
        // stable state; the counter saturates at CNT_LAST so it can never wrap.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state_d = ST_PRESSED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                end
            endcase
        end

        // Channel state and registered outputs; reset drops everything without a release strobe.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_pulse[g]   = pulse_q;
        assign btn_release[g] = rel_q;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Two-channel pushbutton front end for the sequence-detector FSM. It synchronises the raw P1/P2 board inputs to `clk` and debounces them with a programmable hold time. For each channel it produces a clean level, a single-cycle press pulse and a single-cycle release pulse. The FSM consumes `btn_pulse`, so each physical press advances it exactly one state regardless of how long the button is held.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000: consecutive synchronised samples required to accept a level change (10 ms at 100 MHz). Legal range ≥ 2.
- `CNT_W`, default `$clog2(DB_CYCLES)`: debounce counter width. Derived; do not override.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `btn_raw` in 2: raw asynchronous buttons; bit 0 = P1, bit 1 = P2.
- `btn_level` out 2: debounced stable level per channel.
- `btn_pulse` out 2: one-cycle pulse on an accepted 0→1 transition.
- `btn_release` out 2: one-cycle pulse on an accepted 1→0 transition.

## Operation
- Per channel, a 2-flop synchroniser: `sync1 <= btn_raw[i]`, `s <= sync1`. Only `s` is used downstream.
- Per channel, an independent 4-state FSM with counter `cnt[CNT_W-1:0]`:
  - IDLE (stable 0): `s==1` → PRESS_WAIT, `cnt=1`; otherwise stay.
  - PRESS_WAIT: `s==0` → IDLE, `cnt=0`, no pulse. `s==1` and `cnt==DB_CYCLES-1` → PRESSED, `cnt=0`, `btn_level=1`, `btn_pulse=1`. Otherwise `cnt++`.
  - PRESSED (stable 1): `s==0` → RELEASE_WAIT, `cnt=1`; otherwise stay.
  - RELEASE_WAIT: `s==1` → PRESSED, `cnt=0`, no pulse. `s==0` and `cnt==DB_CYCLES-1` → IDLE, `cnt=0`, `btn_level=0`, `btn_release=1`. Otherwise `cnt++`.
- A level change is accepted only when `s` holds the new value on `DB_CYCLES` consecutive sampling edges. Any single opposite sample restarts the count from the old stable state.
- `btn_pulse` and `btn_release` are registered, high for exactly one cycle, and are never high together on a channel.
- Channels are fully independent. Simultaneous presses on P1 and P2 produce simultaneous pulses when their hold times are equal.
- `cnt` never exceeds `DB_CYCLES-1`, so no wrap-around is possible. Holding a button indefinitely gives one pulse only.

## Timing
- Reset, asynchronous, applies immediately and is held while asserted. Synchronisers = 0, FSM = IDLE, `cnt = 0`, `btn_level = 2'b00`, `btn_pulse = 2'b00`, `btn_release = 2'b00`.
- Press latency: raw rises before edge 0 and is held. `sync1` = 1 at edge 0, `s` = 1 at edge 1. PRESS_WAIT is entered at edge 2. `btn_level` and `btn_pulse` go high at edge `DB_CYCLES+1`. `btn_pulse` drops at edge `DB_CYCLES+2`.
- Release latency is symmetric: `DB_CYCLES+1` edges from raw falling to `btn_release`/`btn_level` update.
- Reset asserted mid-debounce or while PRESSED clears all state and drops outputs without a release pulse.
- Reset released while a button is held: the full debounce is required, then one `btn_pulse`.
- Minimum accepted press: `s` high for `DB_CYCLES` edges. A pulse of `DB_CYCLES-1` edges is rejected.

## Test plan
All scenarios use `DB_CYCLES=8`.
- Clean press: P1 raw high for 20 cycles from edge 0 → `btn_level[0]` high at edge 9, `btn_pulse[0]` high only in the cycle after edge 9. Falling raw then gives `btn_release[0]` 9 edges later.
- Bounce: P1 toggles 1,0,1,1,0,1 per cycle, then holds 1 → no pulse during bouncing; exactly one `btn_pulse[0]` 9 edges after the final rising sample.
- Short glitch: P2 high for 7 cycles → `btn_level[1]`, `btn_pulse[1]` and `btn_release[1]` stay 0 throughout.
- Simultaneous: P1 and P2 rise on the same edge and are held → `btn_pulse` = `2'b11` for one cycle at edge 9.
- Long hold: P1 held 1000 cycles → exactly one `btn_pulse[0]` and no further pulses until release.
- Reset mid-operation: assert reset at edge 5 of a press, release at edge 7 with the button still held → outputs 0 during reset; `btn_pulse[0]` occurs 9 edges after reset deassertion, and there is no release pulse.
